// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, keeps one imem request outstanding, holds the result for decode.
// Define IFU_MISALIGN_TRAP_EN to trap misaligned redirects into a FAULT state instead of masking them.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        fetch_fault
);

`ifdef IFU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
`endif

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic        drop, drop_n;
  logic        capture;
  logic [31:0] redirect_target;

`ifdef IFU_MISALIGN_TRAP_EN
  logic fault_q, fault_n;
`endif

  assign redirect_target = redirect_pc & ~32'h3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      drop           <= 1'b0;
      instr_data     <= '0;
      instr_pc       <= '0;
      instr_pc_plus4 <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_q        <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      drop     <= drop_n;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_q  <= fault_n;
`endif
      if (capture) begin
        instr_data     <= imem_rdata;
        instr_pc       <= fetch_pc;
        instr_pc_plus4 <= fetch_pc + 32'd4;
      end
    end
  end

  // A redirect outranks every other event; a response already granted is marked for dropping.
  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    drop_n      = drop;
    capture     = 1'b0;
    imem_req    = (state == REQ);
    imem_addr   = fetch_pc;
    instr_valid = (state == HOLD);
`ifdef IFU_MISALIGN_TRAP_EN
    fault_n     = fault_q;
    fetch_fault = fault_q;
`else
    fetch_fault = 1'b0;
`endif

    if (redirect_valid) begin
      fetch_pc_n = redirect_target;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_n    = 1'b0;
`endif
      case (state)
        REQ: begin
          if (imem_gnt) begin
            drop_n  = 1'b1;
            state_n = WAIT;
          end else begin
            state_n = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop_n  = 1'b0;
            state_n = REQ;
          end else begin
            drop_n  = 1'b1;
            state_n = WAIT;
          end
        end
`ifdef IFU_MISALIGN_TRAP_EN
        FAULT: begin
          if (imem_rvalid) drop_n = 1'b0;
          state_n = REQ;
        end
`endif
        default: state_n = REQ;
      endcase
`ifdef IFU_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        fault_n = 1'b1;
        state_n = FAULT;
      end
`endif
    end else begin
      case (state)
        IDLE: state_n = REQ;
        REQ:  if (imem_gnt) state_n = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop_n  = 1'b0;
              state_n = REQ;
            end else begin
              capture    = 1'b1;
              fetch_pc_n = fetch_pc + 32'd4;
              state_n    = HOLD;
            end
          end
        end
        HOLD: if (instr_ready) state_n = REQ;
`ifdef IFU_MISALIGN_TRAP_EN
        FAULT: if (imem_rvalid) drop_n = 1'b0;
`endif
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder, stream-level scoreboard, directed scenarios.
// Honours IFU_MISALIGN_TRAP_EN the same way the design does.
module tb_instr_fetch_unit;

`ifdef IFU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;
  int rsp_lat = 1;
  logic [31:0] grant_log[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
    .fetch_fault(fetch_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'd3 + 32'h2008_0005;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Memory: grants immediately, answers rsp_lat cycles after the grant cycle.
  logic        mem_grant_q = 1'b0;
  logic        mem_rsp_q = 1'b0;
  logic [31:0] mem_addr_q = '0;
  logic [31:0] pend_addr = '0;
  bit          pend = 1'b0;
  int          cnt = 0;

  always @(negedge clk) begin
    mem_grant_q = imem_req && imem_gnt;
    mem_rsp_q   = imem_rvalid;
    mem_addr_q  = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (mem_rsp_q) pend = 1'b0;
      if (mem_grant_q) begin
        pend      = 1'b1;
        pend_addr = mem_addr_q;
        cnt       = rsp_lat - 1;
      end else if (pend && cnt > 0) begin
        cnt--;
      end
    end
    imem_gnt    = imem_req && !pend;
    imem_rvalid = pend && (cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
  end

  // Stream model: what address must be requested next and which PC decode must see next.
  logic [31:0] exp_fetch = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_data = '0;
  bit          m_fault = 1'b0;
  bit          prev_hold = 1'b0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      checkOutput("rst_req", imem_req, 0);
      checkOutput("rst_valid", instr_valid, 0);
      exp_fetch = 32'h0;
      exp_pc    = 32'h0;
      m_fault   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      checkOutput("fault_flag", fetch_fault, m_fault);
      if (m_fault) begin
        checkOutput("fault_req", imem_req, 0);
        checkOutput("fault_valid", instr_valid, 0);
      end
      if (instr_valid) begin
        checkOutput("pc_plus4", instr_pc_plus4, instr_pc + 32'd4);
        checkOutput("req_while_valid", imem_req, 0);
      end
      if (prev_hold) begin
        checkOutput("hold_valid", instr_valid, 1);
        checkOutput("hold_pc_stable", instr_pc, prev_pc);
        checkOutput("hold_data_stable", instr_data, prev_data);
      end
      if (imem_req) checkOutput("addr_aligned", {30'd0, imem_addr[1:0]}, 0);
      if (redirect_valid) begin
        if (TRAP && redirect_pc[1:0] != 2'b00) begin
          m_fault = 1'b1;
        end else begin
          m_fault   = 1'b0;
          exp_fetch = redirect_pc & ~32'h3;
          exp_pc    = redirect_pc & ~32'h3;
        end
      end else begin
        if (imem_req && imem_gnt) begin
          checkOutput("grant_addr", imem_addr, exp_fetch);
          grant_log.push_back(imem_addr);
          exp_fetch = exp_fetch + 32'd4;
        end
        if (instr_valid && instr_ready) begin
          checkOutput("consume_pc", instr_pc, exp_pc);
          checkOutput("consume_data", instr_data, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
        end
      end
      prev_hold = instr_valid && !instr_ready && !redirect_valid;
      prev_pc   = instr_pc;
      prev_data = instr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit rv, input logic [31:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 40) begin
      tick();
      n++;
    end
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: instr_valid still %b after %0d cycles, expected 1", name, instr_valid, n);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req && n < 40) begin
      tick();
      n++;
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: imem_req still %b after %0d cycles, expected 1", name, imem_req, n);
    end
  endtask

  task automatic wait_grant(input string name, output logic [31:0] addr);
    int sz = grant_log.size();
    int n = 0;
    while (grant_log.size() <= sz && n < 40) begin
      tick();
      n++;
    end
    if (grant_log.size() > sz) begin
      addr = grant_log[grant_log.size() - 1];
    end else begin
      addr = 32'hxxxx_xxxx;
      checks++;
      errors++;
      $display("[TB] FAIL %s: no grant after %0d cycles, got none, expected one", name, n);
    end
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req", imem_req, 0);
    checkOutput("reset_addr", imem_addr, 32'h0);
    checkOutput("reset_valid", instr_valid, 0);
    checkOutput("reset_pc", instr_pc, 32'h0);
    checkOutput("reset_plus4", instr_pc_plus4, 32'h0);
    checkOutput("reset_data", instr_data, 32'h0);
    checkOutput("reset_fault", fetch_fault, 0);
    reset = 1'b0;

    // Best-case fetch of the reset PC, then held by decode for 5 cycles.
    tick();
    checkOutput("first_req", imem_req, 1);
    checkOutput("first_addr", imem_addr, 32'h0);
    tick();
    checkOutput("not_yet_valid", instr_valid, 0);
    tick();
    checkOutput("first_valid", instr_valid, 1);
    checkOutput("first_pc", instr_pc, 32'h0);
    checkOutput("first_plus4", instr_pc_plus4, 32'h4);
    checkOutput("first_data", instr_data, 32'h2008_0005);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_valid", instr_valid, 1);
      checkOutput("stall_req", imem_req, 0);
      checkOutput("stall_pc", instr_pc, 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    wait_grant("after_hold", a);
    checkOutput("after_hold_addr", a, 32'h4);

    // Redirect in the grant cycle of the fetch at 0x8.
    wait_req("third_req");
    checkOutput("third_addr", imem_addr, 32'h8);
    applyStimulus(1'b1, 32'h40, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    wait_grant("redir40_grant", a);
    checkOutput("redir40_addr", a, 32'h40);
    wait_valid("redir40_valid");
    checkOutput("redir40_pc", instr_pc, 32'h40);
    checkOutput("redir40_data", instr_data, 32'h2008_00C5);
    rsp_lat = 5;

    // Redirect while waiting; the old response lands 4 cycles later and must vanish.
    wait_req("req44");
    checkOutput("req44_addr", imem_addr, 32'h44);
    tick();
    applyStimulus(1'b1, 32'h100, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wait_drop_req", imem_req, 0);
    wait_grant("redir100_grant", a);
    checkOutput("redir100_addr", a, 32'h100);
    rsp_lat = 1;
    wait_valid("redir100_valid");
    checkOutput("redir100_pc", instr_pc, 32'h100);
    checkOutput("redir100_data", instr_data, 32'h2008_0305);
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Redirect from HOLD with ready high: not consumed; target wraps past the top of memory.
    tick();
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("redirect_kills_valid", instr_valid, 0);
    wait_valid("wrap_valid");
    checkOutput("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_plus4", instr_pc_plus4, 32'h0);
    checkOutput("wrap_data", instr_data, 32'h2007_FFF9);
    applyStimulus(1'b0, 32'h0, 1'b1);
    wait_grant("wrap_grant", a);
    checkOutput("wrap_next_addr", a, 32'h0);

    // Misaligned redirect.
    applyStimulus(1'b1, 32'h42, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    if (TRAP) begin
      for (int i = 0; i < 6; i++) begin
        checkOutput("trap_fault", fetch_fault, 1);
        checkOutput("trap_no_req", imem_req, 0);
        tick();
      end
      applyStimulus(1'b1, 32'h80, 1'b1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("trap_cleared", fetch_fault, 0);
      wait_grant("trap_grant", a);
      checkOutput("trap_resume_addr", a, 32'h80);
      wait_valid("trap_valid");
      checkOutput("trap_resume_pc", instr_pc, 32'h80);
    end else begin
      checkOutput("mask_fault", fetch_fault, 0);
      wait_grant("mask_grant", a);
      checkOutput("mask_addr", a, 32'h40);
      wait_valid("mask_valid");
      checkOutput("mask_pc", instr_pc, 32'h40);
    end

    // Asynchronous reset in the middle of a transaction.
    wait_req("pre_reset_req");
    tick();
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", instr_valid, 0);
    checkOutput("async_rst_req", imem_req, 0);
    checkOutput("async_rst_addr", imem_addr, 32'h0);
    checkOutput("async_rst_fault", fetch_fault, 0);
    tick();
    reset = 1'b0;
    wait_valid("post_reset_valid");
    checkOutput("post_reset_pc", instr_pc, 32'h0);
    checkOutput("post_reset_data", instr_data, 32'h2008_0005);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly downstream of the PC register/PC+4 logic. Owns the fetch PC and issues one word request at a time to instruction memory over a req/gnt/rvalid handshake. Holds the returned instruction with its PC in an output register for decode, using a valid/ready handshake. Accepts branch/jump redirects that flush any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset; must be word aligned.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  instruction memory request valid
imem_addr  out  32  request byte address, always word aligned
imem_gnt  in  1  memory accepts the request this cycle (while imem_req=1)
imem_rvalid  in  1  read data valid; earliest one cycle after gnt
imem_rdata  in  32  instruction word
redirect_valid  in  1  one-cycle pulse: load redirect_pc, flush
redirect_pc  in  32  branch/jump target
instr_valid  out  1  instr_data/instr_pc hold a valid instruction
instr_ready  in  1  decode consumes the instruction when instr_valid=1
instr_data  out  32  fetched instruction
instr_pc  out  32  address of instr_data
instr_pc_plus4  out  32  instr_pc + 4, modulo 2^32
fetch_fault  out  1  misaligned redirect flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, instr_pc_plus4=0, drop=0, fetch_fault=0.
- IDLE: goes to REQ on the first clock after reset deasserts.
- REQ:
  - imem_req=1, imem_addr=fetch_pc.
  - imem_gnt=1 -> WAIT; otherwise stay in REQ with the address held stable.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 with drop=0: register instr_data=imem_rdata, instr_pc=fetch_pc, instr_pc_plus4=fetch_pc+4, set fetch_pc=fetch_pc+4, set instr_valid=1, go to HOLD.
  - imem_rvalid=1 with drop=1: discard the data, clear drop, go to REQ.
- HOLD:
  - instr_valid=1; outputs stay stable until accepted.
  - instr_ready=1 -> instr_valid=0 next cycle, go to REQ.
- Best-case timing: gnt in the same cycle as req, rvalid the next cycle, gives instr_valid 2 cycles after the REQ cycle and one instruction per 3 cycles. At most one request is outstanding.
- Redirect has priority over every other event in the same cycle:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - instr_valid <= 0, even if instr_ready=1 in the same cycle; that instruction is not consumed.
  - From IDLE or HOLD -> REQ.
  - From REQ with gnt=1 in the same cycle: set drop=1, go to WAIT.
  - From REQ with gnt=0: stay in REQ with the new address next cycle.
  - From WAIT with rvalid=0: set drop=1, stay in WAIT.
  - From WAIT with rvalid=1 in the same cycle: discard the data, go to REQ (drop stays 0).
- Arithmetic: all PC adds are 32-bit unsigned and wrap; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset asserted mid-transaction: immediate return to reset values. Any rvalid arriving after reset deassertion is ignored, because the IDLE and REQ states do not sample rvalid.
- Protocol assumptions on the memory side: rvalid only while in WAIT; imem_rdata only meaningful when rvalid=1.

Optional Feature:
Macro IFU_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 and moves to state FAULT.
  - FAULT: imem_req=0, instr_valid=0.
  - Any pending response is still dropped via drop.
  - FAULT is left only by a subsequent aligned redirect (-> REQ, fetch_fault=0) or by reset.
  - A misaligned redirect while in FAULT keeps FAULT.
- Undefined:
  - redirect_pc[1:0] is silently forced to 00.
  - fetch_fault is tied to 0 and the FAULT state does not exist.

Test Plan:
- Reset release, memory grants immediately with rvalid the next cycle, rdata=32'h2008_0005, instr_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8. First instr_valid 3 cycles after reset release with instr_pc=0, instr_pc_plus4=4, instr_data=32'h2008_0005.
- instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1, instr_data/instr_pc stable, imem_req=0 throughout. After ready=1, next request to 0x4.
- Redirect to 0x40 in the gnt cycle of the fetch at 0x8 -> the response for 0x8 is dropped (no instr_valid). Next imem_addr=0x40, then instr_pc=0x40.
- Redirect to 0x100 while in WAIT, rvalid arriving 4 cycles later -> that data is discarded. Next request to 0x100; instr_valid only for 0x100.
- Redirect to 0xFFFF_FFFC -> instr_pc=0xFFFF_FFFC, instr_pc_plus4=0x0, next imem_addr=0x0.
- Redirect to 0x42: with IFU_MISALIGN_TRAP_EN, fetch_fault=1 and no requests until a redirect to 0x80 (then fault clears, imem_addr=0x80). Without the macro, imem_addr=0x40.
